// File: rtl/wbpipe_mem_if.sv
// Wishbone B4 pipelined bus bundle between a bus master and wbpipe_mem.
interface wbpipe_mem_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic            i_wb_cyc;
    logic            i_wb_stb;
    logic            i_wb_we;
    logic [AW-1:0]   i_wb_addr;
    logic [DW-1:0]   i_wb_data;
    logic [DW/8-1:0] i_wb_sel;
    logic            o_wb_stall;
    logic            o_wb_ack;
    logic            o_wb_err;
    logic [DW-1:0]   o_wb_data;

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
        output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data
    );
endinterface

// File: rtl/wbpipe_mem.sv
// Two-stage pipelined Wishbone B4 memory with optional LFSR-driven stall injection.
// Writes commit at acceptance; reads sample memory one edge later and complete two
// edges after acceptance. Out-of-range addresses complete with err instead of ack.
module wbpipe_mem #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned LGMEMSZ  = 10,
    parameter int unsigned STALL_EN = 0
) (
    input logic         i_clk,
    input logic         i_rst_n,
    wbpipe_mem_if.slave wb
);
    localparam int unsigned Depth    = 1 << LGMEMSZ;
    localparam int unsigned NumLanes = DW / 8;

    // Storage is deliberately not reset so contents survive a reset.
    logic [DW-1:0] mem [Depth];

    logic               stall_q, stall_d;
    logic [7:0]         lfsr_q, lfsr_d;

    logic               s1_valid_q, s1_valid_d;
    logic               s1_we_q, s1_we_d;
    logic               s1_inr_q, s1_inr_d;
    logic [LGMEMSZ-1:0] s1_idx_q, s1_idx_d;

    logic               s2_valid_q, s2_valid_d;
    logic               s2_we_q, s2_we_d;
    logic               s2_inr_q, s2_inr_d;
    logic [DW-1:0]      s2_data_q, s2_data_d;

    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [DW-1:0]      rdata_q, rdata_d;

    logic               accept;
    logic               addr_inr;
    logic [LGMEMSZ-1:0] addr_idx;

    // Request acceptance and address decode for the incoming request.
    always_comb begin
        accept   = i_rst_n && wb.i_wb_cyc && wb.i_wb_stb && !stall_q;
        addr_inr = (wb.i_wb_addr[AW-1:LGMEMSZ] == '0);
        addr_idx = wb.i_wb_addr[LGMEMSZ-1:0];
    end

    // Next-state for stall generator, pipeline stages and response outputs.
    always_comb begin
        lfsr_d     = lfsr_q;
        stall_d    = 1'b0;
        if (STALL_EN != 0) begin
            // Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
            lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            stall_d = lfsr_q[0] & lfsr_q[1];
        end

        s1_valid_d = accept;
        s1_we_d    = s1_we_q;
        s1_inr_d   = s1_inr_q;
        s1_idx_d   = s1_idx_q;
        if (accept) begin
            s1_we_d  = wb.i_wb_we;
            s1_inr_d = addr_inr;
            s1_idx_d = addr_idx;
        end

        // A dropped cyc aborts everything in flight.
        s2_valid_d = wb.i_wb_cyc && s1_valid_q;
        s2_we_d    = s1_we_q;
        s2_inr_d   = s1_inr_q;
        s2_data_d  = s2_data_q;
        if (s1_valid_q && !s1_we_q && s1_inr_q) begin
            s2_data_d = mem[s1_idx_q];
        end

        ack_d   = wb.i_wb_cyc && s2_valid_q && s2_inr_q;
        err_d   = wb.i_wb_cyc && s2_valid_q && !s2_inr_q;
        rdata_d = rdata_q;
        if (wb.i_wb_cyc && s2_valid_q && s2_inr_q && !s2_we_q) begin
            rdata_d = s2_data_q;
        end
    end

    // Pipeline, stall and response registers with asynchronous reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lfsr_q     <= 8'h01;
            stall_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_inr_q   <= 1'b0;
            s1_idx_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_we_q    <= 1'b0;
            s2_inr_q   <= 1'b0;
            s2_data_q  <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            lfsr_q     <= lfsr_d;
            stall_q    <= stall_d;
            s1_valid_q <= s1_valid_d;
            s1_we_q    <= s1_we_d;
            s1_inr_q   <= s1_inr_d;
            s1_idx_q   <= s1_idx_d;
            s2_valid_q <= s2_valid_d;
            s2_we_q    <= s2_we_d;
            s2_inr_q   <= s2_inr_d;
            s2_data_q  <= s2_data_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    // Byte-lane write commit at the acceptance edge.
    always_ff @(posedge i_clk) begin
        if (accept && wb.i_wb_we && addr_inr) begin
            for (int b = 0; b < int'(NumLanes); b++) begin
                if (wb.i_wb_sel[b]) begin
                    mem[addr_idx][b*8 +: 8] <= wb.i_wb_data[b*8 +: 8];
                end
            end
        end
    end

    assign wb.o_wb_stall = stall_q;
    assign wb.o_wb_ack   = ack_q;
    assign wb.o_wb_err   = err_q;
    assign wb.o_wb_data  = rdata_q;
endmodule

// File: tb/tb_wbpipe_mem.sv
// Bench for wbpipe_mem: one instance without and one with stall injection, both
// driven by the same bus inputs and checked against a transaction-level model.
module tb_wbpipe_mem;
    localparam int DEPTH = 1024;

    typedef struct {
        logic        err;
        logic        rd;
        logic [31:0] data;
        int          due;
    } resp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdat = '0;
    logic [3:0]  sel = '0;

    wbpipe_mem_if #(.AW(32), .DW(32)) wb0 ();
    wbpipe_mem_if #(.AW(32), .DW(32)) wb1 ();

    assign wb0.i_wb_cyc = cyc;  assign wb1.i_wb_cyc = cyc;
    assign wb0.i_wb_stb = stb;  assign wb1.i_wb_stb = stb;
    assign wb0.i_wb_we = we;    assign wb1.i_wb_we = we;
    assign wb0.i_wb_addr = addr; assign wb1.i_wb_addr = addr;
    assign wb0.i_wb_data = wdat; assign wb1.i_wb_data = wdat;
    assign wb0.i_wb_sel = sel;  assign wb1.i_wb_sel = sel;

    wbpipe_mem #(.AW(32), .DW(32), .LGMEMSZ(10), .STALL_EN(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .wb(wb0)
    );
    wbpipe_mem #(.AW(32), .DW(32), .LGMEMSZ(10), .STALL_EN(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .wb(wb1)
    );

    logic        ack_o [2], err_o [2], stall_o [2];
    logic [31:0] data_o [2];
    assign ack_o[0] = wb0.o_wb_ack;     assign ack_o[1] = wb1.o_wb_ack;
    assign err_o[0] = wb0.o_wb_err;     assign err_o[1] = wb1.o_wb_err;
    assign stall_o[0] = wb0.o_wb_stall; assign stall_o[1] = wb1.o_wb_stall;
    assign data_o[0] = wb0.o_wb_data;   assign data_o[1] = wb1.o_wb_data;

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mem_m [2][DEPTH];
    resp_t       pq [2][$];
    logic [7:0]  lfsr_m = 8'h01;
    logic        exp_stall [2] = '{1'b0, 1'b0};
    logic        exp_ack [2] = '{1'b0, 1'b0};
    logic        exp_err [2] = '{1'b0, 1'b0};
    logic        exp_rdack [2] = '{1'b0, 1'b0};
    logic [31:0] exp_data [2] = '{32'h0, 32'h0};
    logic        accepted [2] = '{1'b0, 1'b0};
    int          edge_n = 0;

    int n_cmp = 0;
    int n_fail = 0;

    // Drive one bus cycle, advance the model by one edge, settle just past the edge.
    task automatic tick(input logic c, input logic s, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        resp_t r;
        cyc = c; stb = s; we = w; addr = a; wdat = d; sel = b;
        @(posedge clk);
        edge_n++;
        for (int n = 0; n < 2; n++) begin
            exp_ack[n] = 1'b0; exp_err[n] = 1'b0; exp_rdack[n] = 1'b0; accepted[n] = 1'b0;
            if (rst_n) begin
                if (!c) pq[n].delete();
                if (c && s && !exp_stall[n]) begin
                    accepted[n] = 1'b1;
                    if (w && a < DEPTH)
                        for (int i = 0; i < 4; i++)
                            if (b[i]) mem_m[n][a[9:0]][i*8 +: 8] = d[i*8 +: 8];
                    r.err = (a >= DEPTH);
                    r.rd = !w;
                    r.data = (a < DEPTH) ? mem_m[n][a[9:0]] : 32'h0;
                    r.due = edge_n + 2;
                    pq[n].push_back(r);
                end
                if (pq[n].size() > 0 && pq[n][0].due == edge_n) begin
                    r = pq[n].pop_front();
                    exp_ack[n] = !r.err;
                    exp_err[n] = r.err;
                    if (r.rd && !r.err) begin
                        exp_rdack[n] = 1'b1;
                        exp_data[n] = r.data;
                    end
                end
                if (n == 1) begin
                    exp_stall[1] = lfsr_m[0] & lfsr_m[1];
                    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
                end
            end
        end
        #1;
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            pq[n].delete();
            exp_stall[n] = 1'b0; exp_ack[n] = 1'b0; exp_err[n] = 1'b0;
            exp_rdack[n] = 1'b0; exp_data[n] = 32'h0;
        end
        lfsr_m = 8'h01;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) tick(1'b1, 1'b1, 1'b0, 32'd3, 32'h0, 4'hF);
        for (int n = 0; n < 2; n++) begin
            n_cmp++;
            if ({ack_o[n], err_o[n], stall_o[n]} !== 3'b000 || data_o[n] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset[%0d]: ack/err/stall=%b%b%b data=%h, want 000 data=0",
                         n, ack_o[n], err_o[n], stall_o[n], data_o[n]);
            end
        end
        rst_n = 1'b1;
    endtask

    // Writes full words into 0..15 so later random reads see defined data.
    task automatic test_prefill();
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, 1'b1, 1'b1, i, $urandom, 4'hF);
            for (int n = 0; n < 2; n++) begin
                n_cmp++;
                if ({ack_o[n], err_o[n], stall_o[n]} !== {exp_ack[n], exp_err[n], exp_stall[n]}) begin
                    n_fail++;
                    $display("FAIL prefill[%0d]: ack/err/stall=%b%b%b want %b%b%b", n,
                             ack_o[n], err_o[n], stall_o[n], exp_ack[n], exp_err[n], exp_stall[n]);
                end
            end
        end
        repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_write_read();
        logic [2:0] ack_hist = '0;
        tick(1'b1, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF);
        tick(1'b1, 1'b1, 1'b0, 32'd5, 32'h0, 4'h0);
        for (int t = 0; t < 3; t++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            ack_hist[t] = ack_o[0];
            if (t == 1) begin
                n_cmp++;
                if (data_o[0] !== 32'hDEADBEEF) begin
                    n_fail++;
                    $display("FAIL write_read data: got %h want deadbeef", data_o[0]);
                end
            end
        end
        n_cmp++;
        if (ack_hist !== 3'b011) begin
            n_fail++;
            $display("FAIL write_read ack timing: got %b want 011", ack_hist);
        end
    endtask

    task automatic test_byte_sel();
        tick(1'b1, 1'b1, 1'b1, 32'd7, 32'hFFFFFFFF, 4'hF);
        tick(1'b1, 1'b1, 1'b1, 32'd7, 32'h11223344, 4'b0101);
        tick(1'b1, 1'b1, 1'b0, 32'd7, 32'h0, 4'hF);
        repeat (2) tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_cmp++;
        if (ack_o[0] !== 1'b1 || data_o[0] !== 32'hFF22FF44) begin
            n_fail++;
            $display("FAIL byte_sel: ack=%b data=%h want ack=1 data=ff22ff44", ack_o[0], data_o[0]);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_out_of_range();
        logic [3:0] err_hist = '0, ack_hist = '0;
        tick(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        for (int t = 0; t < 4; t++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            err_hist[t] = err_o[0];
            ack_hist[t] = ack_o[0];
        end
        n_cmp++;
        if (err_hist !== 4'b0010 || ack_hist !== 4'b0000) begin
            n_fail++;
            $display("FAIL oor_read: err=%b ack=%b want err=0010 ack=0000", err_hist, ack_hist);
        end
        // An out-of-range write aliasing word 5 must leave word 5 alone.
        tick(1'b1, 1'b1, 1'b1, 32'h405, 32'h0, 4'hF);
        tick(1'b1, 1'b1, 1'b0, 32'd5, 32'h0, 4'h0);
        n_cmp++;
        if (ack_o[0] !== 1'b0 || err_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_idle: ack=%b err=%b want 0 0", ack_o[0], err_o[0]);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_cmp++;
        if (err_o[0] !== 1'b1 || ack_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_write: err=%b ack=%b want err=1 ack=0", err_o[0], ack_o[0]);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        n_cmp++;
        if (ack_o[0] !== 1'b1 || data_o[0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL oor_mem_kept: ack=%b data=%h want ack=1 data=deadbeef",
                     ack_o[0], data_o[0]);
        end
        tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        logic [10:0] ack_hist = '0;
        logic        stall_seen = 1'b0;
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, 1'b1, i, $urandom, 4'hF);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int t = 0; t < 11; t++) begin
            if (t < 8) tick(1'b1, 1'b1, 1'b0, t, 32'h0, 4'h0);
            else tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            ack_hist[t] = ack_o[0];
            stall_seen = stall_seen | stall_o[0];
            if (exp_rdack[0]) begin
                n_cmp++;
                if (data_o[0] !== exp_data[0]) begin
                    n_fail++;
                    $display("FAIL burst data t=%0d: got %h want %h", t, data_o[0], exp_data[0]);
                end
            end
        end
        n_cmp++;
        if (ack_hist !== 11'b01111111100 || stall_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL burst acks: got %b stall=%b want 01111111100 stall=0",
                     ack_hist, stall_seen);
        end
    endtask

    task automatic test_abort();
        int acks = 0;
        tick(1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 4'h0);
        tick(1'b1, 1'b1, 1'b0, 32'd2, 32'h0, 4'h0);
        for (int t = 0; t < 4; t++) begin
            tick(1'b0, 1'b1, 1'b0, 32'd3, 32'h0, 4'h0);
            acks += int'(ack_o[0]) + int'(err_o[0]);
        end
        n_cmp++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL abort: got %0d completions want 0", acks);
        end
        tick(1'b1, 1'b1, 1'b0, 32'd3, 32'h0, 4'h0);
        for (int t = 0; t < 3; t++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            if (t == 1) begin
                n_cmp++;
                if (ack_o[0] !== 1'b1 || data_o[0] !== exp_data[0] || exp_rdack[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL abort_recover: ack=%b data=%h want ack=1 data=%h",
                             ack_o[0], data_o[0], exp_data[0]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        tick(1'b1, 1'b1, 1'b1, 32'd12, 32'hCAFEF00D, 4'hF);
        repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick(1'b1, 1'b1, 1'b0, 32'd12, 32'h0, 4'h0);
        tick(1'b1, 1'b1, 1'b0, 32'd12, 32'h0, 4'h0);
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int n = 0; n < 2; n++) begin
            n_cmp++;
            if ({ack_o[n], err_o[n], stall_o[n]} !== 3'b000 || data_o[n] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_async[%0d]: ack/err/stall=%b%b%b data=%h want 000 0",
                         n, ack_o[n], err_o[n], stall_o[n], data_o[n]);
            end
        end
        for (int t = 0; t < 3; t++) begin
            tick(1'b1, 1'b1, 1'b0, 32'd12, 32'h0, 4'h0);
            acks += int'(ack_o[0]) + int'(ack_o[1]);
        end
        rst_n = 1'b1;
        n_cmp++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL reset_drop: got %0d acks want 0", acks);
        end
        tick(1'b1, 1'b1, 1'b0, 32'd12, 32'h0, 4'h0);
        for (int t = 0; t < 3; t++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            if (t == 1) begin
                n_cmp++;
                if (ack_o[0] !== 1'b1 || data_o[0] !== 32'hCAFEF00D) begin
                    n_fail++;
                    $display("FAIL reset_mem_kept: ack=%b data=%h want ack=1 data=cafef00d",
                             ack_o[0], data_o[0]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int t = 0; t < 300; t++) begin
            a = ($urandom_range(0, 7) == 0) ? (32'h400 << $urandom_range(0, 20)) | 32'd3
                                            : $urandom_range(0, 15);
            tick($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 a, $urandom, 4'($urandom));
            for (int n = 0; n < 2; n++) begin
                n_cmp++;
                if ({ack_o[n], err_o[n], stall_o[n]} !== {exp_ack[n], exp_err[n], exp_stall[n]}) begin
                    n_fail++;
                    $display("FAIL random[%0d] t=%0d: ack/err/stall=%b%b%b want %b%b%b", n, t,
                             ack_o[n], err_o[n], stall_o[n], exp_ack[n], exp_err[n], exp_stall[n]);
                end
                if (exp_rdack[n]) begin
                    n_cmp++;
                    if (data_o[n] !== exp_data[n]) begin
                        n_fail++;
                        $display("FAIL random_data[%0d] t=%0d: got %h want %h", n, t,
                                 data_o[n], exp_data[n]);
                    end
                end
            end
        end
        repeat (3) tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_stall();
        int acks = 0;
        int guard;
        for (int r = 0; r < 16; r++) begin
            guard = 0;
            do begin
                tick(1'b1, 1'b1, r < 8, 32'd20 + 32'(r % 8), 32'hA5000000 + 32'(r), 4'hF);
                guard++;
                acks += int'(ack_o[1]);
                n_cmp++;
                if ({ack_o[1], err_o[1], stall_o[1]} !== {exp_ack[1], exp_err[1], exp_stall[1]}) begin
                    n_fail++;
                    $display("FAIL stall_seq req=%0d: ack/err/stall=%b%b%b want %b%b%b", r,
                             ack_o[1], err_o[1], stall_o[1], exp_ack[1], exp_err[1], exp_stall[1]);
                end
                if (exp_rdack[1]) begin
                    n_cmp++;
                    if (data_o[1] !== exp_data[1]) begin
                        n_fail++;
                        $display("FAIL stall_data req=%0d: got %h want %h", r,
                                 data_o[1], exp_data[1]);
                    end
                end
            end while (!accepted[1] && guard < 64);
            if (!accepted[1]) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stall_timeout req=%0d: not accepted in 64 cycles", r);
            end
        end
        for (int t = 0; t < 3; t++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            acks += int'(ack_o[1]);
        end
        n_cmp++;
        if (acks != 16) begin
            n_fail++;
            $display("FAIL stall_acks: got %0d want 16", acks);
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_write_read();
        test_byte_sel();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
